// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end.
// It tracks the PC, reads one word at a time, holds the word for the decoder and predicts branches with a 2-bit BHT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        stall,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  input  logic        br_update,
  input  logic [31:0] br_update_pc,
  input  logic        br_taken,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        decoder_enable,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  output logic        predict,
  input  logic [31:0] branch_predict
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, ISSUE = 3'd2, WAIT_JR = 3'd3, FLUSH = 3'd4;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  logic [2:0] state, state_nx;
  logic [31:0] pc, pc_nx, jal_off;
  logic [1:0] bht [0:(1<<BHT_BITS)-1];
  logic [BHT_BITS-1:0] idx, upd_idx;
  logic [1:0] upd_cnt;
  logic pred_q, unused_ok;
  assign idx = pc[BHT_BITS+1:2];
  assign upd_idx = br_update_pc[BHT_BITS+1:2];
  assign upd_cnt = bht[upd_idx];
  assign jal_off = {{11{inst_out[31]}}, inst_out[31], inst_out[19:12], inst_out[20], inst_out[30:21], 1'b0};
  assign mem_req = state == FETCH;
  assign mem_addr = pc;
  assign decoder_enable = state == ISSUE;
  assign predict = decoder_enable && pred_q;
  assign unused_ok = ^{br_update_pc[31:BHT_BITS+2], br_update_pc[1:0], pc_nx[1:0], inst_out[11:7]};
  // A clear while a read is still outstanding must park in FLUSH so the stale reply is swallowed.
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    if (state == IDLE) state_nx = FETCH;
    else if (clear) begin
      pc_nx = clear_pc;
      state_nx = (state == FETCH || state == FLUSH) && !mem_valid ? FLUSH : FETCH;
    end
    else if (state == FETCH) state_nx = mem_valid ? ISSUE : FETCH;
    else if (state == FLUSH) state_nx = mem_valid ? FETCH : FLUSH;
    else if (state == ISSUE && !stall) begin
      state_nx = inst_out[6:0] == OP_JALR ? WAIT_JR : FETCH;
      pc_nx = inst_out[6:0] == OP_BR ? branch_predict :
              inst_out[6:0] == OP_JAL ? pc + jal_off :
              inst_out[6:0] == OP_JALR ? pc : pc + 32'd4;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      inst_out <= '0;
      inst_pc_out <= '0;
      pred_q <= 1'b0;
    end else if (rdy) begin
      state <= state_nx;
      pc <= {pc_nx[31:2], pc[1:0]};
      if (state == FETCH && mem_valid && !clear) begin
        inst_out <= mem_rdata;
        inst_pc_out <= pc;
        pred_q <= mem_rdata[6:0] == OP_BR && bht[idx][1];
      end
    end
  // Prediction is captured with the word, so a same-edge update is seen only by later fetches.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < (1<<BHT_BITS); i++) bht[i] <= 2'b01;
    else if (rdy && br_update)
      bht[upd_idx] <= br_taken ? (upd_cnt == 2'b11 ? upd_cnt : upd_cnt + 2'd1)
                               : (upd_cnt == 2'b00 ? upd_cnt : upd_cnt - 2'd1);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random-stimulus bench for fetch_unit.
// A transaction-level model tracks the expected fetch address, issued word and BHT counters.
module tb_fetch_unit;
  logic clk = 0, rst_n = 1, rdy = 0, stall = 0, clear = 0, br_update = 0, br_taken = 0, mem_valid = 0;
  logic [31:0] clear_pc = 0, br_update_pc = 0, mem_rdata = 0, branch_predict = 0;
  logic mem_req, decoder_enable, predict;
  logic [31:0] mem_addr, inst_out, inst_pc_out;
  int total = 0, bad = 0;

  fetch_unit dut (.clk(clk), .rst_n(rst_n), .rdy(rdy), .stall(stall), .clear(clear), .clear_pc(clear_pc),
    .br_update(br_update), .br_update_pc(br_update_pc), .br_taken(br_taken), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .decoder_enable(decoder_enable),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out), .predict(predict), .branch_predict(branch_predict));

  always #5 clk = ~clk;

  logic [31:0] prog [logic [31:0]];
  int bht_m [64];
  logic [31:0] exp_pc, exp_inst, exp_ipc, out_addr;
  logic exp_issue, exp_pred, jr_wait, out_q, dropped, started;
  int cnt, idle_cnt;
  int lat_min = 1, lat_max = 1, p_stall = 0, p_clear = 0, p_upd = 0, p_rdy0 = 0, p_jr = 0;
  logic f_clear = 0, f_upd = 0, f_taken = 0;
  logic [31:0] f_clear_pc = 0, f_upd_pc = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bimm(logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] jimm(logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] enc_b(int off);
    logic [12:0] m;
    m = off[12:0];
    return {m[12], m[10:5], 5'd2, 5'd1, 3'b000, m[4:1], m[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(int off);
    logic [20:0] m;
    m = off[20:0];
    return {m[20], m[10:1], m[11], m[19:12], 5'd1, 7'b1101111};
  endfunction
  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] h;
    if (prog.exists(a)) return prog[a];
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    case (h[2:0])
      3'd4, 3'd5: return enc_b((int'(h[7:4]) - 8) * 4);
      3'd6: return enc_j((int'(h[7:4]) - 8) * 8);
      3'd7: return h[8] ? 32'h00008067 : enc_j(32);
      default: return {h[31:20], 5'd1, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  task automatic reset_model();
    exp_pc = 0; exp_inst = 0; exp_ipc = 0; out_addr = 0;
    exp_issue = 0; exp_pred = 0; jr_wait = 0; out_q = 0; dropped = 0; started = 0;
    cnt = 0; idle_cnt = 0;
    for (int i = 0; i < 64; i++) bht_m[i] = 1;
  endtask

  task automatic rst_chk(string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_den"}, decoder_enable, 0);
    chk({tag, "_inst"}, inst_out, 0);
    chk({tag, "_ipc"}, inst_pc_out, 0);
    chk({tag, "_pred"}, predict, 0);
  endtask

  task automatic release_rst();
    rdy = 0; stall = 0; clear = 0; br_update = 0; mem_valid = 0;
    @(negedge clk);
    rst_n = 1;
    reset_model();
  endtask

  // One clock: check outputs, drive the next inputs, then advance the model across the coming edge.
  task automatic cycle();
    logic deliv, ddrop, exp_req;
    int k;
    @(negedge clk);
    exp_req = started && !exp_issue && !jr_wait && !(out_q && dropped);
    chk("den", decoder_enable, exp_issue);
    chk("req", mem_req, exp_req);
    if (exp_req) chk("addr", mem_addr, out_q ? out_addr : exp_pc);
    if (exp_issue) begin
      chk("inst", inst_out, exp_inst);
      chk("ipc", inst_pc_out, exp_ipc);
      chk("pred", predict, exp_pred);
    end
    idle_cnt = (exp_issue || jr_wait) ? 0 : idle_cnt + 1;
    if (idle_cnt == 300) chk("watchdog", idle_cnt, 0);
    rdy = $urandom_range(99) >= p_rdy0;
    stall = exp_issue && $urandom_range(99) < p_stall;
    clear = f_clear || (started && !(out_q && dropped && cnt == 0) &&
                        $urandom_range(99) < (jr_wait ? p_jr : p_clear));
    clear_pc = f_clear ? f_clear_pc : 32'($urandom_range(255)) << 2;
    br_update = f_upd || $urandom_range(99) < p_upd;
    br_taken = f_upd ? f_taken : 1'($urandom_range(1));
    br_update_pc = f_upd ? f_upd_pc : ($urandom_range(1) ? exp_ipc : $urandom);
    f_clear = 0;
    f_upd = 0;
    branch_predict = exp_issue && exp_inst[6:0] == 7'b1100011 ? exp_ipc + (exp_pred ? bimm(exp_inst) : 32'd4) : $urandom;
    deliv = 0; ddrop = 0; mem_valid = 0; mem_rdata = $urandom;
    if (rdy) begin
      if (out_q) begin
        if (cnt == 0) begin
          deliv = 1; ddrop = dropped; out_q = 0; dropped = 0;
          mem_valid = 1; mem_rdata = mem_word(out_addr);
        end else cnt--;
      end else if (exp_req) begin
        out_q = 1; out_addr = exp_pc; cnt = $urandom_range(lat_max, lat_min) - 1;
      end
    end
    if (rdy) begin
      if (clear) begin
        exp_pc = clear_pc; exp_issue = 0; jr_wait = 0;
        if (out_q) dropped = 1;
      end else if (deliv && !ddrop) begin
        exp_issue = 1; exp_inst = mem_rdata; exp_ipc = out_addr;
        exp_pred = mem_rdata[6:0] == 7'b1100011 && bht_m[out_addr[7:2]] >= 2;
      end else if (exp_issue && !stall) begin
        exp_issue = 0;
        case (exp_inst[6:0])
          7'b1100011: exp_pc = branch_predict;
          7'b1101111: exp_pc = exp_ipc + jimm(exp_inst);
          7'b1100111: jr_wait = 1;
          default: exp_pc = exp_ipc + 4;
        endcase
      end
      if (br_update) begin
        k = br_update_pc[7:2];
        bht_m[k] = br_taken ? (bht_m[k] == 3 ? 3 : bht_m[k] + 1) : (bht_m[k] == 0 ? 0 : bht_m[k] - 1);
      end
      started = 1;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_jr();
    int n = 0;
    while (!jr_wait && n < 300) begin cycle(); n++; end
    if (!jr_wait) chk("jr_timeout", n, 0);
  endtask

  task automatic async_rst();
    int n = 0;
    while (!exp_issue && n < 300) begin cycle(); n++; end
    if (!exp_issue) chk("issue_timeout", n, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_den", decoder_enable, exp_issue);
    rst_n = 0;
    #1;
    rst_chk("async_rst");
    release_rst();
  endtask

  initial begin
    reset_model();
    prog[32'h0] = 32'h00100093; prog[32'h4] = 32'h00100093;
    prog[32'h8] = 32'h00100093; prog[32'hc] = 32'h00100093;
    prog[32'h10] = enc_b(16);
    prog[32'h14] = enc_j(12);
    prog[32'h20] = enc_j(32'h100);
    prog[32'h120] = enc_j(-224);
    prog[32'h40] = 32'h00008067;
    prog[32'h80] = 32'h00008067;
    #1 rst_n = 0;
    #3 rst_chk("reset");
    release_rst();
    run_until_jr();
    run(4);
    f_clear = 1; f_clear_pc = 32'h80;
    run_until_jr();
    f_upd = 1; f_upd_pc = 32'h10; f_taken = 1;
    cycle();
    f_upd = 1; f_upd_pc = 32'h10; f_taken = 1;
    cycle();
    f_clear = 1; f_clear_pc = 32'h10;
    run_until_jr();
    p_stall = 70; p_jr = 30;
    f_clear = 1; f_clear_pc = 32'h0;
    run(200);
    p_stall = 0; lat_min = 4; lat_max = 4; p_clear = 10;
    run(300);
    lat_min = 1; lat_max = 5; p_stall = 30; p_clear = 5; p_upd = 30; p_rdy0 = 15;
    run(3000);
    p_rdy0 = 0;
    async_rst();
    run(500);
    p_rdy0 = 100;
    run(5);
    p_rdy0 = 0;
    run(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front-end that produces the instruction stream the decoder consumes. It maintains the PC and issues 32-bit instruction reads to the memory controller. It holds each returned word until the decoder accepts it, and picks the next PC from a 2-bit bimodal branch history table (BHT) plus the decoder's combinational branch target. On clear it redirects to the resolved PC and discards any in-flight read.

Parameters:
RESET_PC, 32'h0, PC loaded at reset
BHT_BITS, 6, log2 of BHT entries; index = pc[BHT_BITS+1:2]

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
rdy  input  1  global ready; low freezes all state
stall  input  1  decoder/dispatch backpressure; instruction not accepted this cycle
clear  input  1  misprediction/jump redirect
clear_pc  input  32  redirect target, valid with clear
br_update  input  1  resolved-branch BHT update strobe
br_update_pc  input  32  PC of resolved branch
br_taken  input  1  resolved outcome
mem_req  output  1  instruction read request, held until mem_valid
mem_addr  output  32  read address (= pc)
mem_valid  input  1  one-cycle read-data pulse
mem_rdata  input  32  instruction word
decoder_enable  output  1  inst_out valid for decoder
inst_out  output  32  instruction to decode
inst_pc_out  output  32  PC of inst_out
predict  output  1  predicted-taken flag for inst_out
branch_predict  input  32  decoder's next-PC for a branch: PC+BImm if predict, else PC+4

Behaviour:
- Reset (rst_n low, async): state=IDLE, pc=RESET_PC, inst_out=0, inst_pc_out=0. All outputs 0. All BHT entries = 2'b01 (weakly not-taken).
- rdy=0: no state, pc, BHT or register changes. The memory controller does not pulse mem_valid while rdy=0.
- States: IDLE, FETCH, ISSUE, WAIT_JR, FLUSH.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH: mem_req=1, mem_addr=pc. On mem_valid: latch inst_out=mem_rdata, inst_pc_out=pc, then -> ISSUE. Read latency is arbitrary, at least 1 cycle.
- ISSUE: decoder_enable=1. predict = BHT[pc idx][1] if opcode (inst[6:0]) = 1100011, else 0.
- ISSUE, stall=0: instruction is consumed at this edge. Next PC depends on opcode:
  - branch: pc<=branch_predict, -> FETCH
  - JAL (1101111): pc<=pc+sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}), -> FETCH
  - JALR (1100111): -> WAIT_JR, pc unchanged
  - other: pc<=pc+4, -> FETCH
- ISSUE, stall=1: hold all outputs unchanged.
- WAIT_JR: decoder_enable=0, mem_req=0; waits for clear.
- clear has priority over every transition, in every state except IDLE:
  - pc<=clear_pc and decoder_enable drops next cycle.
  - If state=FETCH and mem_valid=0 (read outstanding): -> FLUSH.
  - Otherwise (including clear coincident with mem_valid, whose data is dropped): -> FETCH.
- FLUSH: mem_req=0; on mem_valid discard data, -> FETCH. A clear in FLUSH updates pc only and stays in FLUSH.
- Arithmetic: PC adds are 32-bit, wrap modulo 2^32. pc[1:0] is never modified.
- BHT update on br_update (rdy=1), entry at br_update_pc index: taken -> saturating increment (max 11); not taken -> saturating decrement (min 00).
  - Update and lookup on the same index in the same cycle: lookup sees the old value; update lands at the edge.
- Throughput: at most one instruction per 2 cycles (FETCH, then ISSUE). Minimum latency from mem_valid to decoder_enable is 1 cycle.

Test Plan:
- Reset release with RESET_PC=0, memory latency 1, word 32'h00100093 (addi) -> mem_req with addr 0 at cycle 2. decoder_enable with inst_pc_out=0, predict=0. Next fetch addr 4.
- Branch at pc 0x10 with BHT entry at 01 -> predict=0, next fetch = branch_predict (0x14). Apply br_update taken twice -> entry 11; refetch 0x10 -> predict=1, next fetch = branch_predict.
- JAL at 0x20 with offset +0x100 -> next mem_addr=0x120. JALR at 0x40 -> mem_req stays 0 until clear with clear_pc=0x80, then fetch 0x80.
- stall=1 for 3 cycles in ISSUE -> inst_out, inst_pc_out, predict stable and decoder_enable=1 throughout; pc advances only after stall drops.
- clear with clear_pc=0x200 during an outstanding read (latency 4) -> FLUSH; stale mem_valid data never reaches inst_out; next mem_addr=0x200. Repeat with clear coincident with mem_valid -> data dropped, fetch 0x200.
- rst_n asserted mid-ISSUE -> all outputs 0 immediately, asynchronously. BHT reads 01 everywhere after release. rdy=0 for 5 cycles mid-FETCH -> no state change.
